// File: rtl/mcdf_ctrl_regs_n.sv
// Control/status register file for the multi-channel data formatter.
// Per-channel enable/priority/packet-length controls, margin watermarks and full-event interrupts.
module mcdf_ctrl_regs_n #(
  parameter int NUM_CH       = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int MARGIN_WIDTH = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int PRIO_WIDTH   = 2,
  parameter int PKGLEN_WIDTH = 3
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [1:0]                     cmd_i,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]          cmd_data_i,
  output logic [DATA_WIDTH-1:0]          cmd_data_o,
  output logic                           cmd_rvalid_o,
  output logic                           cmd_err_o,
  input  logic [NUM_CH*MARGIN_WIDTH-1:0] slv_margin_i,
  output logic [NUM_CH-1:0]              slv_en_o,
  output logic [NUM_CH*PRIO_WIDTH-1:0]   slv_prio_o,
  output logic [NUM_CH*PKGLEN_WIDTH-1:0] slv_pkglen_o,
  output logic                           irq_o
);

  // Command handshake: a command is accepted on every clock edge where cmd_i is
  // write (01) or read (10); there is no back-pressure. Read data and the error
  // strobe come back exactly one cycle later as single-cycle pulses.
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b10;
  localparam int CTRL_W = 1 + PRIO_WIDTH + PKGLEN_WIDTH;
  localparam logic [CTRL_W-1:0]       CTRL_RST  = CTRL_W'(7);
  localparam logic [MARGIN_WIDTH-1:0] DEPTH_RST = MARGIN_WIDTH'(FIFO_DEPTH);

  logic [31:0]                    addr32;
  logic [2:0]                     ch_idx;
  logic                           aligned;
  logic                           ctrl_hit, stat_hit, irq_stat_hit, irq_en_hit, map_hit;
  logic                           wr, rd;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic [NUM_CH*CTRL_W-1:0]       ctrl_all;
  logic [NUM_CH*MARGIN_WIDTH-1:0] margin_all;
  logic [NUM_CH*MARGIN_WIDTH-1:0] wmark_all;
  logic [NUM_CH-1:0]              full_evt;
  logic [NUM_CH-1:0]              irq_stat_q, irq_en_q, irq_clr;
  logic                           unused_bits;

  assign addr32       = 32'(cmd_addr_i);
  assign ch_idx       = addr32[4:2];
  assign aligned      = (addr32[1:0] == 2'b00);
  assign ctrl_hit     = aligned && (addr32 < 32'(4 * NUM_CH));
  assign stat_hit     = aligned && (addr32 >= 32'h40) && (addr32 < 32'(64 + 4 * NUM_CH));
  assign irq_stat_hit = (addr32 == 32'h80);
  assign irq_en_hit   = (addr32 == 32'h84);
  assign map_hit      = ctrl_hit || stat_hit || irq_stat_hit || irq_en_hit;
  assign wr           = (cmd_i == CMD_WR);
  assign rd           = (cmd_i == CMD_RD);
  assign irq_clr      = (wr && irq_stat_hit) ? cmd_data_i[NUM_CH-1:0] : '0;
  assign unused_bits  = ^{cmd_data_i, addr32};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CTRL_W-1:0]       ctrl_q;
    logic [MARGIN_WIDTH-1:0] margin_q, wmark_q, margin_in, wmark_base;
    logic                    ctrl_wr, stat_wr;

    assign margin_in  = slv_margin_i[g*MARGIN_WIDTH +: MARGIN_WIDTH];
    assign ctrl_wr    = wr && ctrl_hit && (ch_idx == 3'(g));
    assign stat_wr    = wr && stat_hit && (ch_idx == 3'(g));
    // A STAT write restarts tracking from the current margin, but a lower incoming margin still wins.
    assign wmark_base = stat_wr ? margin_q : wmark_q;
    assign full_evt[g] = (margin_q != '0) && (margin_in == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        ctrl_q   <= CTRL_RST;
        margin_q <= DEPTH_RST;
        wmark_q  <= DEPTH_RST;
      end else begin
        if (ctrl_wr) ctrl_q <= cmd_data_i[CTRL_W-1:0];
        margin_q <= margin_in;
        wmark_q  <= (margin_in < wmark_base) ? margin_in : wmark_base;
      end
    end

    assign ctrl_all[g*CTRL_W +: CTRL_W]               = ctrl_q;
    assign margin_all[g*MARGIN_WIDTH +: MARGIN_WIDTH] = margin_q;
    assign wmark_all[g*MARGIN_WIDTH +: MARGIN_WIDTH]  = wmark_q;
    assign slv_en_o[g]                                = ctrl_q[0];
    assign slv_prio_o[g*PRIO_WIDTH +: PRIO_WIDTH]     = ctrl_q[PRIO_WIDTH:1];
    assign slv_pkglen_o[g*PKGLEN_WIDTH +: PKGLEN_WIDTH] = ctrl_q[CTRL_W-1:PRIO_WIDTH+1];
  end

  // Unmapped addresses fall through to zero read data.
  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ctrl_hit && (ch_idx == 3'(n))) rd_data[CTRL_W-1:0] = ctrl_all[n*CTRL_W +: CTRL_W];
      if (stat_hit && (ch_idx == 3'(n))) begin
        rd_data[MARGIN_WIDTH-1:0]  = margin_all[n*MARGIN_WIDTH +: MARGIN_WIDTH];
        rd_data[8 +: MARGIN_WIDTH] = wmark_all[n*MARGIN_WIDTH +: MARGIN_WIDTH];
      end
    end
    if (irq_stat_hit) rd_data[NUM_CH-1:0] = irq_stat_q;
    if (irq_en_hit)   rd_data[NUM_CH-1:0] = irq_en_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_stat_q   <= '0;
      irq_en_q     <= '0;
      irq_o        <= 1'b0;
      cmd_data_o   <= '0;
      cmd_rvalid_o <= 1'b0;
      cmd_err_o    <= 1'b0;
    end else begin
      // A full event in the same cycle as its clear keeps the bit set.
      irq_stat_q <= (irq_stat_q & ~irq_clr) | full_evt;
      if (wr && irq_en_hit) irq_en_q <= cmd_data_i[NUM_CH-1:0];
      irq_o        <= |(irq_stat_q & irq_en_q);
      cmd_rvalid_o <= rd;
      cmd_err_o    <= (rd || wr) && !map_hit;
      if (rd) cmd_data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_mcdf_ctrl_regs_n.sv
// Bench for mcdf_ctrl_regs_n: directed literal checks followed by random traffic
// compared every cycle against a register-map level model.
module tb_mcdf_ctrl_regs_n;
  localparam int NUM_CH = 3;
  localparam int DW     = 32;
  localparam int AW     = 8;
  localparam int MW     = 8;
  localparam int DEPTH  = 32;
  localparam int PW     = 2;
  localparam int KW     = 3;
  localparam logic [31:0] CTRL_MASK = (32'd1 << (1 + PW + KW)) - 1;
  localparam logic [31:0] CH_MASK   = (32'd1 << NUM_CH) - 1;

  logic                   clk_i;
  logic                   rstn_i;
  logic [1:0]             cmd_i;
  logic [AW-1:0]          cmd_addr_i;
  logic [DW-1:0]          cmd_data_i;
  logic [DW-1:0]          cmd_data_o;
  logic                   cmd_rvalid_o;
  logic                   cmd_err_o;
  logic [NUM_CH*MW-1:0]   slv_margin_i;
  logic [NUM_CH-1:0]      slv_en_o;
  logic [NUM_CH*PW-1:0]   slv_prio_o;
  logic [NUM_CH*KW-1:0]   slv_pkglen_o;
  logic                   irq_o;

  logic [MW-1:0] in_margin [NUM_CH];

  int n_checks = 0;
  int n_errors = 0;

  mcdf_ctrl_regs_n #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MARGIN_WIDTH(MW),
    .FIFO_DEPTH(DEPTH), .PRIO_WIDTH(PW), .PKGLEN_WIDTH(KW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cmd_i(cmd_i), .cmd_addr_i(cmd_addr_i),
    .cmd_data_i(cmd_data_i), .cmd_data_o(cmd_data_o), .cmd_rvalid_o(cmd_rvalid_o),
    .cmd_err_o(cmd_err_o), .slv_margin_i(slv_margin_i), .slv_en_o(slv_en_o),
    .slv_prio_o(slv_prio_o), .slv_pkglen_o(slv_pkglen_o), .irq_o(irq_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    slv_margin_i = '0;
    for (int n = 0; n < NUM_CH; n++) slv_margin_i[n*MW +: MW] = in_margin[n];
  end

  // ---------------- reference model ----------------
  logic [31:0] m_ctrl   [NUM_CH];
  logic [31:0] m_margin [NUM_CH];
  logic [31:0] m_wmark  [NUM_CH];
  logic [31:0] m_irq_stat, m_irq_en, m_rdata;
  logic        m_irq, m_rvalid, m_err;

  // kind: 0 unmapped, 1 CTRL, 2 STAT, 3 IRQ_STAT, 4 IRQ_EN
  function automatic int decode(input logic [31:0] a, output int ch);
    ch = int'(a[5:2]);
    if (a[1:0] != 2'b00) return 0;
    if (a < 4 * NUM_CH) return 1;
    if (a >= 32'h40 && a < 32'h40 + 4 * NUM_CH) return 2;
    if (a == 32'h80) return 3;
    if (a == 32'h84) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] reg_value(input int kind, input int ch);
    case (kind)
      1: return m_ctrl[ch];
      2: return (m_wmark[ch] << 8) | m_margin[ch];
      3: return m_irq_stat;
      4: return m_irq_en;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_ctrl[n] = 32'h7; m_margin[n] = DEPTH; m_wmark[n] = DEPTH;
    end
    m_irq_stat = 0; m_irq_en = 0; m_rdata = 0;
    m_irq = 0; m_rvalid = 0; m_err = 0;
  endtask

  task automatic model_step();
    int kind, ch;
    logic [31:0] clr, evt, base, newm;
    kind = decode(32'(cmd_addr_i), ch);
    m_irq    = (m_irq_stat & m_irq_en) != 0;
    m_rvalid = (cmd_i == 2'b10);
    m_err    = (cmd_i == 2'b01 || cmd_i == 2'b10) && kind == 0;
    if (cmd_i == 2'b10) m_rdata = reg_value(kind, ch);
    clr = 0; evt = 0;
    if (cmd_i == 2'b01) begin
      if (kind == 1) m_ctrl[ch] = cmd_data_i & CTRL_MASK;
      if (kind == 3) clr = cmd_data_i & CH_MASK;
      if (kind == 4) m_irq_en = cmd_data_i & CH_MASK;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      newm = 32'(in_margin[n]);
      base = (cmd_i == 2'b01 && kind == 2 && ch == n) ? m_margin[n] : m_wmark[n];
      m_wmark[n] = (newm < base) ? newm : base;
      if (m_margin[n] != 0 && newm == 0) evt = evt | (32'd1 << n);
      m_margin[n] = newm;
    end
    m_irq_stat = (m_irq_stat & ~clr) | evt;
  endtask

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    logic [NUM_CH-1:0]    e_en;
    logic [NUM_CH*PW-1:0] e_prio;
    logic [NUM_CH*KW-1:0] e_pkg;
    for (int n = 0; n < NUM_CH; n++) begin
      e_en[n]            = m_ctrl[n][0];
      e_prio[n*PW +: PW] = PW'(m_ctrl[n] >> 1);
      e_pkg[n*KW +: KW]  = KW'(m_ctrl[n] >> (1 + PW));
    end
    check("cmp_en",     32'(slv_en_o),     32'(e_en));
    check("cmp_prio",   32'(slv_prio_o),   32'(e_prio));
    check("cmp_pkglen", 32'(slv_pkglen_o), 32'(e_pkg));
    check("cmp_rvalid", 32'(cmd_rvalid_o), 32'(m_rvalid));
    check("cmp_err",    32'(cmd_err_o),    32'(m_err));
    check("cmp_rdata",  cmd_data_o,        m_rdata);
    check("cmp_irq",    32'(irq_o),        32'(m_irq));
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    cmd_i = 2'b01; cmd_addr_i = AW'(addr); cmd_data_i = data;
    @(negedge clk_i);
    cmd_i = 2'b00;
  endtask

  task automatic rd_lit(input string name, input logic [31:0] addr,
                        input logic [31:0] exp, input logic exp_err);
    @(negedge clk_i);
    cmd_i = 2'b10; cmd_addr_i = AW'(addr);
    @(negedge clk_i);
    cmd_i = 2'b00;
    check({name, "_rvalid"}, 32'(cmd_rvalid_o), 32'd1);
    check({name, "_data"},   cmd_data_o,        exp);
    check({name, "_err"},    32'(cmd_err_o),    32'(exp_err));
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 12))
      0: return 32'h00;  1: return 32'h04;  2: return 32'h08;  3: return 32'h0C;
      4: return 32'h40;  5: return 32'h44;  6: return 32'h48;  7: return 32'h4C;
      8: return 32'h80;  9: return 32'h84;  10: return 32'h90; 11: return 32'h02;
      default: return 32'h3C;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rstn_i = 1'b0; cmd_i = 2'b00; cmd_addr_i = '0; cmd_data_i = '0;
    for (int n = 0; n < NUM_CH; n++) in_margin[n] = MW'(DEPTH);
    repeat (3) @(negedge clk_i);
    check("rst_en",   32'(slv_en_o),   32'h7);
    check("rst_prio", 32'(slv_prio_o), 32'h3F);
    check("rst_irq",  32'(irq_o),      32'h0);
    rstn_i = 1'b1;

    rd_lit("rst_ctrl0", 32'h00, 32'h07, 1'b0);
    rd_lit("rst_ctrl1", 32'h04, 32'h07, 1'b0);
    rd_lit("rst_ctrl2", 32'h08, 32'h07, 1'b0);
    rd_lit("rst_stat1", 32'h44, 32'h2020, 1'b0);
    rd_lit("rst_irqst", 32'h80, 32'h0, 1'b0);

    wr(32'h04, 32'hFFFF_FFFE);
    check("ctrl1_en",     32'(slv_en_o[1]),         32'h0);
    check("ctrl1_prio",   32'(slv_prio_o[3:2]),     32'h3);
    check("ctrl1_pkglen", 32'(slv_pkglen_o[5:3]),   32'h7);
    rd_lit("ctrl1_rd", 32'h04, 32'h3E, 1'b0);

    @(negedge clk_i); in_margin[2] = 8'd10;
    @(negedge clk_i); in_margin[2] = 8'd20;
    rd_lit("stat2_wm", 32'h48, 32'h0A14, 1'b0);
    wr(32'h48, 32'hDEAD_BEEF);
    rd_lit("stat2_reload", 32'h48, 32'h1414, 1'b0);

    wr(32'h84, 32'h4);
    @(negedge clk_i); in_margin[2] = 8'd5;
    @(negedge clk_i); in_margin[2] = 8'd0;
    rd_lit("irq_set", 32'h80, 32'h4, 1'b0);
    check("irq_high", 32'(irq_o), 32'h1);
    wr(32'h80, 32'h4);
    @(negedge clk_i);
    check("irq_low", 32'(irq_o), 32'h0);
    rd_lit("irq_clr", 32'h80, 32'h0, 1'b0);
    @(negedge clk_i); in_margin[2] = 8'd5;
    @(negedge clk_i);
    in_margin[2] = 8'd0; cmd_i = 2'b01; cmd_addr_i = 8'h80; cmd_data_i = 32'h4;
    @(negedge clk_i); cmd_i = 2'b00;
    rd_lit("irq_setwins", 32'h80, 32'h4, 1'b0);

    rd_lit("unmap_0c", 32'h0C, 32'h0, 1'b1);
    rd_lit("unmap_4c", 32'h4C, 32'h0, 1'b1);
    wr(32'h90, 32'hFFFF_FFFF);
    check("unmap_wr_err", 32'(cmd_err_o), 32'h1);
    rd_lit("unmap_wr_en", 32'h84, 32'h4, 1'b0);

    // Reset lands just after the edge that registered a read.
    @(negedge clk_i); cmd_i = 2'b10; cmd_addr_i = 8'h00;
    @(posedge clk_i); #1; rstn_i = 1'b0; cmd_i = 2'b00;
    for (int n = 0; n < NUM_CH; n++) in_margin[n] = MW'(DEPTH);
    @(negedge clk_i);
    check("rst2_rvalid", 32'(cmd_rvalid_o), 32'h0);
    check("rst2_irq",    32'(irq_o),        32'h0);
    check("rst2_en",     32'(slv_en_o),     32'h7);
    check("rst2_data",   cmd_data_o,        32'h0);
    rstn_i = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_i);
      cmd_i      = 2'($urandom_range(0, 3));
      cmd_addr_i = AW'(pick_addr());
      cmd_data_i = $urandom();
      for (int n = 0; n < NUM_CH; n++)
        if ($urandom_range(0, 3) == 0)
          in_margin[n] = ($urandom_range(0, 4) == 0) ? 8'd0 : MW'($urandom_range(0, 40));
    end
    @(negedge clk_i); cmd_i = 2'b00;
    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
